// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state types and helpers for the parametrised UART.
// Holds tx/rx state enums, the 3-sample majority vote and oversample range check.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  localparam int OS_MIN = 8;
  localparam int OS_MAX = 32;

  function automatic logic majority3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic bit os_valid(input int os);
    return (os >= OS_MIN) && (os <= OS_MAX) &&
           (os % 2 == 0);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: down-counting oversample tick divider.
// Ports: clk, rst (sync, high), load (restart count), tick (1 clk at count 0).
module uart_baud_tick #(
  parameter int CLOCK_DIVIDE = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic tick
);

  localparam int CW = $clog2(CLOCK_DIVIDE);
  localparam logic [CW-1:0] RELOAD =
    CW'(CLOCK_DIVIDE - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || load || (cnt == '0)) begin
      cnt <= RELOAD;
    end else begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/uart_param.sv
// uart_param: full-duplex UART, configurable width/stop/oversample, valid/ready.
// Ports: clk, rst (sync, high), rx/tx pins, tx_valid/tx_ready/tx_data,
// rx_valid/rx_ready/rx_data, rx_frame_err, rx_par_err, rx_overrun pulses,
// is_receiving. Define UART_PARITY_EN to add a parity bit to both directions.
module uart_param
  import uart_pkg::*;
#(
  parameter int CLOCK_DIVIDE = 27,
  parameter int OVERSAMPLE   = 16,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_frame_err,
  output logic                 rx_par_err,
  output logic                 rx_overrun,
  output logic                 is_receiving
);

  if (!os_valid(OVERSAMPLE)) begin : g_bad_os
    $error("OVERSAMPLE must be even, 8..32");
  end

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [TW-1:0] T_LAST =
    TW'(OVERSAMPLE - 1);
  // tick index t counts ticks t+1 into the bit;
  // votes at OVERSAMPLE/2-1, /2, /2+1
  localparam logic [TW-1:0] T_S0 =
    TW'(OVERSAMPLE / 2 - 2);
  localparam logic [TW-1:0] T_S1 =
    TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S2 =
    TW'(OVERSAMPLE / 2);
  localparam logic [BW-1:0] B_LAST =
    BW'(DATA_BITS - 1);
  localparam logic S_LAST = 1'(STOP_BITS - 1);

`ifdef UART_PARITY_EN
  localparam logic PAR_INV = (PARITY_ODD != 0);
`endif

  // ---------------- transmitter ----------------

  tx_state_e           tx_state;
  logic [TW-1:0]       tx_tcnt;
  logic [BW-1:0]       tx_bcnt;
  logic                tx_scnt;
  logic [DATA_BITS-1:0] tx_shr;
  logic                tx_tick;
  logic                tx_load;
  logic                tx_bit_end;
  logic                tx_stop_done;
`ifdef UART_PARITY_EN
  logic                tx_par;
`endif

  uart_baud_tick #(
    .CLOCK_DIVIDE(CLOCK_DIVIDE)
  ) u_tx_tick (
    .clk (clk),
    .rst (rst),
    .load(tx_load),
    .tick(tx_tick)
  );

  assign tx_bit_end =
    tx_tick && (tx_tcnt == T_LAST);

  // ready in the last stop cycle too, so a
  // held tx_valid chains frames without a gap
  assign tx_stop_done =
    (tx_state == TX_STOP) && tx_bit_end &&
    (tx_scnt == S_LAST);

  assign tx_ready =
    (tx_state == TX_IDLE) || tx_stop_done;

  assign tx_load = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      tx       <= 1'b1;
      tx_tcnt  <= '0;
      tx_bcnt  <= '0;
      tx_scnt  <= 1'b0;
      tx_shr   <= '0;
`ifdef UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_load) begin
      tx_state <= TX_START;
      tx       <= 1'b0;
      tx_tcnt  <= '0;
      tx_shr   <= tx_data;
`ifdef UART_PARITY_EN
      tx_par   <= (^tx_data) ^ PAR_INV;
`endif
    end else if (tx_tick &&
                 (tx_state != TX_IDLE)) begin
      tx_tcnt <= tx_bit_end ? '0 :
                 tx_tcnt + 1'b1;
      if (tx_bit_end) begin
        unique case (tx_state)
          TX_START: begin
            tx       <= tx_shr[0];
            tx_bcnt  <= '0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bcnt == B_LAST) begin
`ifdef UART_PARITY_EN
              tx       <= tx_par;
              tx_state <= TX_PARITY;
`else
              tx       <= 1'b1;
              tx_scnt  <= 1'b0;
              tx_state <= TX_STOP;
`endif
            end else begin
              tx      <= tx_shr[1];
              tx_shr  <= tx_shr >> 1;
              tx_bcnt <= tx_bcnt + 1'b1;
            end
          end
          TX_PARITY: begin
            tx       <= 1'b1;
            tx_scnt  <= 1'b0;
            tx_state <= TX_STOP;
          end
          TX_STOP: begin
            if (tx_scnt == S_LAST) begin
              tx_state <= TX_IDLE;
            end else begin
              tx_scnt <= tx_scnt + 1'b1;
            end
          end
          default: tx_state <= TX_IDLE;
        endcase
      end
    end
  end

  // ---------------- receiver ----------------

  logic                 rx_s1;
  logic                 rx_s2;
  rx_state_e            rx_state;
  logic [TW-1:0]        rx_tcnt;
  logic [BW-1:0]        rx_bcnt;
  logic [DATA_BITS-1:0] rx_shr;
  logic                 rx_smp0;
  logic                 rx_smp1;
  logic                 rx_tick;
  logic                 rx_load;
  logic                 rx_maj;
  logic                 par_bad;
`ifdef UART_PARITY_EN
  logic                 rx_pbad;
  assign par_bad = rx_pbad;
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  uart_baud_tick #(
    .CLOCK_DIVIDE(CLOCK_DIVIDE)
  ) u_rx_tick (
    .clk (clk),
    .rst (rst),
    .load(rx_load),
    .tick(rx_tick)
  );

  assign rx_load =
    (rx_state == RX_IDLE) && !rx_s2;

  assign rx_maj =
    majority3(rx_smp0, rx_smp1, rx_s2);

  assign is_receiving = (rx_state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state     <= RX_IDLE;
      rx_tcnt      <= '0;
      rx_bcnt      <= '0;
      rx_shr       <= '0;
      rx_smp0      <= 1'b1;
      rx_smp1      <= 1'b1;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_frame_err <= 1'b0;
      rx_par_err   <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef UART_PARITY_EN
      rx_pbad      <= 1'b0;
`endif
    end else begin
      rx_frame_err <= 1'b0;
      rx_par_err   <= 1'b0;
      rx_overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (rx_load) begin
        rx_state <= RX_START;
        rx_tcnt  <= '0;
      end else if (rx_tick &&
                   (rx_state != RX_IDLE)) begin
        rx_tcnt <= (rx_tcnt == T_LAST) ? '0 :
                   rx_tcnt + 1'b1;
        if (rx_tcnt == T_S0) rx_smp0 <= rx_s2;
        if (rx_tcnt == T_S1) rx_smp1 <= rx_s2;
        unique case (rx_state)
          RX_START: begin
            // start bit must still be low at
            // mid-bit; advance only at bit end
            if ((rx_tcnt == T_S1) && rx_s2) begin
              rx_state <= RX_IDLE;
            end else if (rx_tcnt == T_LAST) begin
              rx_bcnt  <= '0;
              rx_state <= RX_DATA;
            end
          end
          RX_DATA: begin
            if (rx_tcnt == T_S2) begin
              rx_shr <= {rx_maj,
                         rx_shr[DATA_BITS-1:1]};
              if (rx_bcnt == B_LAST) begin
`ifdef UART_PARITY_EN
                rx_state <= RX_PARITY;
`else
                rx_state <= RX_STOP;
`endif
              end else begin
                rx_bcnt <= rx_bcnt + 1'b1;
              end
            end
          end
          RX_PARITY: begin
            if (rx_tcnt == T_S2) begin
`ifdef UART_PARITY_EN
              rx_pbad <= rx_maj ^ (^rx_shr) ^
                         PAR_INV;
`endif
              rx_state <= RX_STOP;
            end
          end
          RX_STOP: begin
            // leave at mid-stop so a following
            // start edge is never missed
            if (rx_tcnt == T_S2) begin
              rx_state     <= RX_IDLE;
              rx_frame_err <= !rx_maj;
              rx_par_err   <= par_bad;
              if (rx_maj && !par_bad) begin
                if (!rx_valid || rx_ready) begin
                  rx_data  <= rx_shr;
                  rx_valid <= 1'b1;
                end else begin
                  rx_overrun <= 1'b1;
                end
              end
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_param.sv
// tb_uart_param: directed self-checking bench for uart_param.
// Loopback and pin-driven rx frames at 64 clk per bit.
module tb_uart_param;

  localparam int CD  = 4;
  localparam int OS  = 16;
  localparam int BIT = CD * OS;
`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = BIT * NBITS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx;
  logic       tx;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       rx_par_err;
  logic       rx_overrun;
  logic       is_receiving;

  logic loop   = 1'b0;
  logic rx_drv = 1'b1;
  assign rx = loop ? tx : rx_drv;

  int n_chk = 0;
  int n_err = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_ovr = 0;
  int cyc = 0;
  int acc[$];
  logic [7:0] rxq[$];

  uart_param #(
    .CLOCK_DIVIDE(CD),
    .OVERSAMPLE  (OS),
    .DATA_BITS   (8),
    .STOP_BITS   (1),
    .PARITY_ODD  (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .tx          (tx),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_frame_err(rx_frame_err),
    .rx_par_err  (rx_par_err),
    .rx_overrun  (rx_overrun),
    .is_receiving(is_receiving)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rx_frame_err) n_ferr++;
    if (rx_par_err) n_perr++;
    if (rx_overrun) n_ovr++;
    if (tx_valid && tx_ready) acc.push_back(cyc);
    if (rx_valid && rx_ready) rxq.push_back(rx_data);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rx_frame(input logic [7:0] d,
                          input logic stop_v,
                          input logic par_v);
    rx_drv = 1'b0;
    step(BIT);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      step(BIT);
    end
`ifdef UART_PARITY_EN
    rx_drv = par_v;
    step(BIT);
`else
    if (par_v === 1'bx) rx_drv = 1'b1;
`endif
    rx_drv = stop_v;
    step(BIT);
    rx_drv = 1'b1;
  endtask

  task automatic wait_rxv(input string tag);
    for (int i = 0; i < 2000 && !rx_valid; i++)
      step(1);
    chk(tag, 32'(rx_valid), 1);
  endtask

  initial begin
    logic [7:0] e;

    // reset state
    step(3);
    chk("rst_tx", 32'(tx), 1);
    chk("rst_tx_ready", 32'(tx_ready), 1);
    chk("rst_rx_valid", 32'(rx_valid), 0);
    chk("rst_rx_data", 32'(rx_data), 0);
    chk("rst_errs", 32'({rx_frame_err,
        rx_par_err, rx_overrun}), 0);
    chk("rst_receiving", 32'(is_receiving), 0);
    rst = 1'b0;
    step(5);

    // loopback 0xA5, exact bit period
    loop = 1'b1;
    e = 8'hA5;
    tx_data = e;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    chk("a5_start_first", 32'(tx), 0);
    chk("a5_busy", 32'(tx_ready), 0);
    step(BIT - 1);
    chk("a5_start_last", 32'(tx), 0);
    step(1);
    chk("a5_bit0_edge", 32'(tx), 1);
    step(BIT / 2);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("a5_bit%0d", i),
          32'(tx), 32'(e[i]));
      step(BIT);
    end
`ifdef UART_PARITY_EN
    chk("a5_parity", 32'(tx), 0);
    step(BIT);
`endif
    chk("a5_stop", 32'(tx), 1);
    wait_rxv("a5_rx_valid");
    chk("a5_rx_data", 32'(rx_data), 32'h0A5);
    chk("a5_no_ferr", 32'(n_ferr), 0);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk("a5_rx_clear", 32'(rx_valid), 0);
    loop = 1'b0;
    step(200);

    // 20-clk start glitch
    rx_drv = 1'b0;
    step(10);
    chk("glitch_recv", 32'(is_receiving), 1);
    step(10);
    rx_drv = 1'b1;
    step(60);
    chk("glitch_idle", 32'(is_receiving), 0);
    chk("glitch_no_valid", 32'(rx_valid), 0);
    chk("glitch_no_ferr", 32'(n_ferr), 0);
    chk("glitch_no_perr", 32'(n_perr), 0);

    // stop bit low
    rx_frame(8'h3C, 1'b0, ^8'h3C);
    step(200);
    chk("ferr_count", 32'(n_ferr), 1);
    chk("ferr_no_valid", 32'(rx_valid), 0);
    chk("ferr_no_perr", 32'(n_perr), 0);

    // overrun
    rx_frame(8'h11, 1'b1, ^8'h11);
    rx_frame(8'h22, 1'b1, ^8'h22);
    step(20);
    chk("ovr_valid", 32'(rx_valid), 1);
    chk("ovr_data", 32'(rx_data), 32'h11);
    chk("ovr_count", 32'(n_ovr), 1);
    chk("ovr_ferr", 32'(n_ferr), 1);
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
    chk("ovr_clear", 32'(rx_valid), 0);

    // back-to-back tx with held tx_valid
    acc.delete();
    rxq.delete();
    loop = 1'b1;
    rx_ready = 1'b1;
    tx_data = 8'h55;
    tx_valid = 1'b1;
    for (int i = 0; i < 100 && acc.size() < 1; i++)
      step(1);
    tx_data = 8'hAA;
    for (int i = 0; i < 2000 && acc.size() < 2; i++)
      step(1);
    tx_valid = 1'b0;
    chk("b2b_accepts", 32'(acc.size()), 2);
    chk("b2b_second_start", 32'(tx), 0);
    if (acc.size() >= 2)
      chk("b2b_gap", 32'(acc[1] - acc[0]), FRAME);
    else
      chk("b2b_gap", 0, FRAME);
    step(FRAME + 100);
    chk("b2b_rx_count", 32'(rxq.size()), 2);
    if (rxq.size() >= 2) begin
      chk("b2b_rx0", 32'(rxq[0]), 32'h55);
      chk("b2b_rx1", 32'(rxq[1]), 32'hAA);
    end
    chk("b2b_no_ovr", 32'(n_ovr), 1);
    rx_ready = 1'b0;
    loop = 1'b0;
    step(50);

`ifdef UART_PARITY_EN
    // 0x07 needs even parity 1; send 0
    rx_frame(8'h07, 1'b1, 1'b0);
    step(50);
    chk("par_count", 32'(n_perr), 1);
    chk("par_no_valid", 32'(rx_valid), 0);
    chk("par_no_ferr", 32'(n_ferr), 1);
`endif

    // reset mid-frame
    tx_data = 8'h00;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    step(100);
    chk("midrst_before", 32'(tx), 0);
    rst = 1'b1;
    step(1);
    chk("midrst_tx", 32'(tx), 1);
    chk("midrst_ready", 32'(tx_ready), 1);
    rst = 1'b0;
    step(5);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
